// File: rtl/ring_inject_arbiter_if.sv
// ring_inject_arbiter_if: local flit sources plus router port 0 injection/credit signals
interface ring_inject_arbiter_if #(
    parameter int NUM_SOURCES = 4,
    parameter int DEST_WIDTH  = 4,
    parameter int FLIT_WIDTH  = 256
);
    logic [NUM_SOURCES-1:0][FLIT_WIDTH-1:0] src_data;
    logic [NUM_SOURCES-1:0][DEST_WIDTH-1:0] src_dest;
    logic [NUM_SOURCES-1:0]                 src_is_tail;
    logic [NUM_SOURCES-1:0]                 src_valid;
    logic [NUM_SOURCES-1:0]                 src_ready;
    logic [FLIT_WIDTH-1:0]                  data_out;
    logic [DEST_WIDTH-1:0]                  dest_out;
    logic                                   is_tail_out;
    logic                                   send_out;
    logic                                   credit_in;
    logic                                   credit_overflow;
    modport master (
        output src_data, src_dest, src_is_tail, src_valid, credit_in,
        input  src_ready, data_out, dest_out, is_tail_out, send_out, credit_overflow
    );
    modport slave (
        input  src_data, src_dest, src_is_tail, src_valid, credit_in,
        output src_ready, data_out, dest_out, is_tail_out, send_out, credit_overflow
    );
endinterface

// File: rtl/ring_inject_arbiter.sv
// ring_inject_arbiter: packet-level round-robin injection arbiter with credit tracking
module ring_inject_arbiter #(
    parameter int NUM_SOURCES       = 4,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_WIDTH        = 256,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    ring_inject_arbiter_if.slave bus
);
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam int PW = $clog2(NUM_SOURCES);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state, state_nx;
    logic [PW-1:0] rr_ptr, rr_nx, owner, owner_nx, winner, grant, idx;
    logic [CW-1:0] credits, credits_nx;
    logic          found, accept, full, overflow;
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        // scan downward so the source closest to rr_ptr wins last
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_SOURCES);
            if (bus.src_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
    assign grant         = (state == LOCKED) ? owner : winner;
    assign bus.src_ready = ((state == LOCKED || found) && credits != '0) ? NUM_SOURCES'(1) << grant : '0;
    assign accept        = |(bus.src_ready & bus.src_valid);
    assign full          = credits == CW'(FLIT_BUFFER_DEPTH);
    assign overflow      = bus.credit_in & ~accept & full;
    assign credits_nx    = (accept & ~bus.credit_in) ? credits - 1'b1 :
                           (bus.credit_in & ~accept & ~full) ? credits + 1'b1 : credits;
    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        owner_nx = owner;
        if (accept) begin
            state_nx = bus.src_is_tail[grant] ? IDLE : LOCKED;
            owner_nx = grant;
            rr_nx    = !bus.src_is_tail[grant] ? rr_ptr :
                       (grant == PW'(NUM_SOURCES - 1)) ? '0 : grant + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            owner               <= '0;
            credits             <= CW'(FLIT_BUFFER_DEPTH);
            bus.credit_overflow <= 1'b0;
            bus.send_out        <= 1'b0;
            bus.is_tail_out     <= 1'b0;
            bus.data_out        <= '0;
            bus.dest_out        <= '0;
        end else begin
            state        <= state_nx;
            rr_ptr       <= rr_nx;
            owner        <= owner_nx;
            credits      <= credits_nx;
            bus.send_out <= accept;
            if (overflow) bus.credit_overflow <= 1'b1;
            if (accept) begin
                bus.data_out    <= bus.src_data[grant];
                bus.dest_out    <= bus.src_dest[grant];
                bus.is_tail_out <= bus.src_is_tail[grant];
            end
        end
    end
endmodule

// File: tb/tb_ring_inject_arbiter.sv
// tb_ring_inject_arbiter: directed packets checked cycle by cycle against a queue-based model
module tb_ring_inject_arbiter;
    localparam int NS = 4, DW = 4, FW = 256, DEPTH = 2;
    logic clk = 1'b0, rst = 1'b1;
    ring_inject_arbiter_if #(.NUM_SOURCES(NS), .DEST_WIDTH(DW), .FLIT_WIDTH(FW)) bus ();
    ring_inject_arbiter #(.NUM_SOURCES(NS), .DEST_WIDTH(DW), .FLIT_WIDTH(FW), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    int tests = 0, fails = 0;
    logic [20:0] q [NS][$];
    int log_q[$];
    logic [NS-1:0] hold = '0, fired = '0;
    logic [7:0] seq = '0;
    bit credit_mode = 0, pulse = 0, started = 0;
    int m_cred, m_rr, m_owner;
    bit m_locked, m_send, m_tail, m_ovf;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int model_grant();
        int s;
        if (m_cred == 0) return -1;
        if (m_locked) return m_owner;
        for (int k = 0; k < NS; k++) begin
            s = (m_rr + k) % NS;
            if (bus.src_valid[s[1:0]]) return s;
        end
        return -1;
    endfunction
    always @(posedge clk) begin
        int g;
        bit acc;
        started = 1;
        if (rst) begin
            m_cred = DEPTH; m_rr = 0; m_owner = 0; m_locked = 0;
            m_send = 0; m_tail = 0; m_ovf = 0; m_data = '0; m_dest = '0;
        end else begin
            g = model_grant();
            acc = (g >= 0) && bus.src_valid[g[1:0]];
            m_send = acc;
            if (acc) begin
                m_data = bus.src_data[g[1:0]];
                m_dest = bus.src_dest[g[1:0]];
                m_tail = bus.src_is_tail[g[1:0]];
                m_locked = !m_tail;
                m_owner = g;
                if (m_tail) m_rr = (g + 1) % NS;
            end
            if (acc && !bus.credit_in) m_cred--;
            else if (!acc && bus.credit_in) begin
                if (m_cred == DEPTH) m_ovf = 1;
                else m_cred++;
            end
        end
    end
    always @(negedge clk) begin
        int g;
        if (started) begin
            g = model_grant();
            fired = bus.src_valid & bus.src_ready;
            check("src_ready", bus.src_ready, (g < 0) ? 4'b0 : 4'(1 << g));
            check("send_out", bus.send_out, m_send);
            check("credit_overflow", bus.credit_overflow, m_ovf);
            if (m_send) begin
                check("data_out", bus.data_out, m_data);
                check("dest_out", bus.dest_out, m_dest);
                check("is_tail_out", bus.is_tail_out, m_tail);
            end
            if (bus.send_out) log_q.push_back(int'(bus.data_out[15:8]));
        end
    end
    task automatic drive();
        logic [20:0] v;
        for (int i = 0; i < NS; i++) begin
            v = (q[i].size() > 0) ? q[i][0] : '0;
            bus.src_valid[i]   = (q[i].size() > 0) && !hold[i];
            bus.src_data[i]    = FW'(v[15:0]);
            bus.src_dest[i]    = v[19:16];
            bus.src_is_tail[i] = v[20];
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) if (fired[i] && q[i].size() > 0) void'(q[i].pop_front());
        bus.credit_in = credit_mode ? bus.send_out : pulse;
        drive();
        #1;
    endtask
    task automatic push(input int s, input int n, input int d);
        for (int j = 0; j < n; j++) begin
            q[s].push_back({1'(j == n - 1), 4'(d), 8'(s), seq});
            seq++;
        end
    endtask
    function automatic bit pending();
        for (int i = 0; i < NS; i++) if (q[i].size() > 0) return 1;
        return 0;
    endfunction
    task automatic drain();
        int n = 0;
        while ((pending() || bus.send_out) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 200, 1);
        repeat (2) tick();
    endtask
    task automatic expect_seq(input string name, input int start, input int n, input logic [31:0] exp);
        logic [31:0] act = '0;
        int t;
        for (int i = 0; i < n; i++) begin
            t = (start + i < log_q.size()) ? log_q[start + i] : 15;
            act = (act << 4) | 32'(t[3:0]);
        end
        check(name, act, exp);
    endtask
    initial begin
        int base;
        bus.src_valid = '0; bus.src_data = '0; bus.src_dest = '0; bus.src_is_tail = '0; bus.credit_in = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_send_out", bus.send_out, 0);
        check("rst_is_tail", bus.is_tail_out, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_dest", bus.dest_out, 0);
        check("rst_overflow", bus.credit_overflow, 0);
        repeat (10) tick();
        check("idle_no_send", log_q.size(), 0);
        check("idle_ready", bus.src_ready, 0);
        // single-flit packet from source 2, credits held back
        push(2, 1, 3);
        drive();
        #1;
        check("t2_ready", bus.src_ready, 4'b0100);
        tick();
        check("t2_send", bus.send_out, 1);
        check("t2_dest", bus.dest_out, 3);
        check("t2_tail", bus.is_tail_out, 1);
        pulse = 1; tick(); pulse = 0;
        credit_mode = 1;
        // two 3-flit packets with the owner stalling mid-packet
        base = log_q.size();
        push(0, 3, 1); push(1, 3, 2);
        drive();
        tick();
        hold[0] = 1; drive();
        repeat (3) tick();
        hold[0] = 0; drive();
        drain();
        expect_seq("t3_order", base, 6, 32'h000111);
        base = log_q.size();
        push(1, 1, 4); push(2, 1, 5);
        drive();
        drain();
        expect_seq("rr_after_t3", base, 2, 32'h21);
        // all sources busy: strict rotation, one flit per cycle
        base = log_q.size();
        for (int r = 0; r < 2; r++) for (int i = 0; i < NS; i++) push(i, 1, i);
        drive();
        repeat (9) tick();
        check("t4_rate", log_q.size() - base, 8);
        expect_seq("t4_order", base, 8, 32'h23012301);
        drain();
        // credit starvation, one flit released per credit pulse
        credit_mode = 0;
        base = log_q.size();
        push(0, 4, 6);
        drive();
        repeat (8) tick();
        check("t5_two_sent", log_q.size() - base, 2);
        check("t5_stalled", bus.src_ready, 0);
        pulse = 1; tick(); pulse = 0;
        repeat (4) tick();
        check("t5_third", log_q.size() - base, 3);
        pulse = 1; tick(); pulse = 0;
        repeat (4) tick();
        check("t5_fourth", log_q.size() - base, 4);
        check("t5_q_empty", q[0].size(), 0);
        pulse = 1; repeat (2) tick(); pulse = 0;
        tick();
        check("t6_no_ovf", bus.credit_overflow, 0);
        pulse = 1; tick(); pulse = 0;
        tick();
        check("t6_ovf", bus.credit_overflow, 1);
        repeat (3) tick();
        check("t6_ovf_sticky", bus.credit_overflow, 1);
        // reset in the middle of a packet owned by source 1
        credit_mode = 1;
        push(1, 3, 7);
        drive();
        repeat (2) tick();
        push(0, 1, 1);
        drive();
        rst = 1'b1;
        tick();
        check("t6_rst_send", bus.send_out, 0);
        check("t6_rst_ovf", bus.credit_overflow, 0);
        for (int i = 0; i < NS; i++) q[i].delete();
        rst = 1'b0;
        base = log_q.size();
        push(0, 1, 2); push(3, 1, 3);
        drive();
        #1;
        check("t6_idle_rr0", bus.src_ready, 4'b0001);
        drain();
        expect_seq("t6_order", base, 2, 32'h03);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
